qtime_uploader: RTL and testbench

- Sits directly downstream of the packet processor and consumes its 512-bit queue-timeout record stream.
- Buffers the records in an internal FIFO and packs them into host-memory write bursts.
- Each burst is a command beat (vaddr, byte length) followed by 64-byte data beats.
- Writes go into a host ring of 64-byte slots starting at a configured base vaddr; a partial batch is flushed after an idle timeout.

---
 rtl/qtime_uploader.sv | 157 +++++++++++++++
 tb/tb_qtime_uploader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qtime_uploader.sv
// Queue-timeout record uploader: buffers 512-bit records and writes them into a
// host ring of 64-byte slots as command + data bursts, flushing partial batches on idle.
module qtime_uploader #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned MAX_BATCH = 16
) (
  input  logic         clock,
  input  logic         reset,
  output logic         io_rec_in_ready,
  input  logic         io_rec_in_valid,
  input  logic [511:0] io_rec_in_bits,
  input  logic [63:0]  io_base_vaddr,
  input  logic [31:0]  io_ring_entries,
  input  logic [31:0]  io_batch_len,
  input  logic [31:0]  io_flush_cycles,
  input  logic         io_dma_cmd_ready,
  output logic         io_dma_cmd_valid,
  output logic [63:0]  io_dma_cmd_bits_vaddr,
  output logic [31:0]  io_dma_cmd_bits_length,
  input  logic         io_dma_data_ready,
  output logic         io_dma_data_valid,
  output logic [511:0] io_dma_data_bits_data,
  output logic         io_dma_data_bits_last,
  output logic [31:0]  io_wr_idx,
  output logic [31:0]  io_uploaded_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned NW = $clog2(MAX_BATCH + 1);
  localparam int unsigned RW = 512;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t state, state_nxt;

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          fifo_full, fifo_empty;
  logic          push, pop;

  logic [31:0] timer;
  logic [31:0] wr_idx, uploaded_cnt, ring_lat;
  logic [NW-1:0] n_q, beat;
  logic [63:0] vaddr_q;
  logic [31:0] length_q;

  logic [31:0] eff_batch, start_idx, room, cnt32, n32, wr_idx_adv;
  logic        go, cmd_hs, data_hs, last_beat;

  // Record FIFO: pointers carry one extra wrap bit so full and empty differ.
  assign count      = wr_ptr - rd_ptr;
  assign fifo_full  = (count == PW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = io_rec_in_valid && io_rec_in_ready;
  assign pop        = data_hs;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= io_rec_in_bits;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Burst sizing from the live config; only consumed at the IDLE decision.
  always_comb begin
    cnt32 = 32'(count);
    if (io_batch_len == 32'd0)                  eff_batch = 32'd1;
    else if (io_batch_len > 32'(MAX_BATCH))     eff_batch = 32'(MAX_BATCH);
    else                                        eff_batch = io_batch_len;
    start_idx = (wr_idx >= io_ring_entries) ? 32'd0 : wr_idx;
    room      = io_ring_entries - start_idx;
    n32       = cnt32;
    if (eff_batch < n32) n32 = eff_batch;
    if (room < n32)      n32 = room;
    go = (state == S_IDLE) && (io_ring_entries != 32'd0) &&
         ((cnt32 >= eff_batch) || ((cnt32 != 32'd0) && (timer >= io_flush_cycles)));
  end

  assign cmd_hs     = io_dma_cmd_valid && io_dma_cmd_ready;
  assign data_hs    = io_dma_data_valid && io_dma_data_ready;
  assign last_beat  = (beat == n_q - NW'(1));
  assign wr_idx_adv = wr_idx + 32'(n_q);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt             = state;
    io_dma_cmd_valid      = 1'b0;
    io_dma_data_valid     = 1'b0;
    io_dma_data_bits_last = 1'b0;
    case (state)
      S_IDLE: if (go) state_nxt = S_CMD;
      S_CMD: begin
        io_dma_cmd_valid = 1'b1;
        if (io_dma_cmd_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        io_dma_data_valid     = !fifo_empty;
        io_dma_data_bits_last = last_beat;
        if (!fifo_empty && io_dma_data_ready && last_beat) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Idle timer, burst latches, ring index and delivery counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer        <= '0;
      wr_idx       <= '0;
      uploaded_cnt <= '0;
      ring_lat     <= '0;
      n_q          <= '0;
      beat         <= '0;
      vaddr_q      <= '0;
      length_q     <= '0;
    end else begin
      if (push || fifo_empty)                       timer <= '0;
      else if (state == S_IDLE && timer != '1)      timer <= timer + 32'd1;

      if (go) begin
        n_q      <= NW'(n32);
        vaddr_q  <= io_base_vaddr + {26'd0, start_idx, 6'd0};
        length_q <= {n32[25:0], 6'd0};
        wr_idx   <= start_idx;
        ring_lat <= io_ring_entries;
      end

      if (cmd_hs) beat <= '0;

      if (data_hs) begin
        beat         <= beat + NW'(1);
        uploaded_cnt <= uploaded_cnt + 32'd1;
        if (last_beat) wr_idx <= (wr_idx_adv == ring_lat) ? 32'd0 : wr_idx_adv;
      end
    end
  end

  assign io_rec_in_ready        = !fifo_full && !reset;
  assign io_dma_cmd_bits_vaddr  = vaddr_q;
  assign io_dma_cmd_bits_length = length_q;
  assign io_dma_data_bits_data  = mem[rd_ptr[AW-1:0]];
  assign io_wr_idx              = wr_idx;
  assign io_uploaded_cnt        = uploaded_cnt;

endmodule

// File: tb/tb_qtime_uploader.sv
// Directed bench for qtime_uploader: ring placement, flush timing, wrap,
// backpressure, disabled ring and mid-burst reset, with sequence-tagged records.
module tb_qtime_uploader;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_rec_in_ready;
  logic         io_rec_in_valid;
  logic [511:0] io_rec_in_bits;
  logic [63:0]  io_base_vaddr;
  logic [31:0]  io_ring_entries;
  logic [31:0]  io_batch_len;
  logic [31:0]  io_flush_cycles;
  logic         io_dma_cmd_ready;
  logic         io_dma_cmd_valid;
  logic [63:0]  io_dma_cmd_bits_vaddr;
  logic [31:0]  io_dma_cmd_bits_length;
  logic         io_dma_data_ready;
  logic         io_dma_data_valid;
  logic [511:0] io_dma_data_bits_data;
  logic         io_dma_data_bits_last;
  logic [31:0]  io_wr_idx;
  logic [31:0]  io_uploaded_cnt;

  qtime_uploader #(.DEPTH(32), .MAX_BATCH(16)) dut (
    .clock(clock), .reset(reset),
    .io_rec_in_ready(io_rec_in_ready), .io_rec_in_valid(io_rec_in_valid),
    .io_rec_in_bits(io_rec_in_bits), .io_base_vaddr(io_base_vaddr),
    .io_ring_entries(io_ring_entries), .io_batch_len(io_batch_len),
    .io_flush_cycles(io_flush_cycles), .io_dma_cmd_ready(io_dma_cmd_ready),
    .io_dma_cmd_valid(io_dma_cmd_valid), .io_dma_cmd_bits_vaddr(io_dma_cmd_bits_vaddr),
    .io_dma_cmd_bits_length(io_dma_cmd_bits_length), .io_dma_data_ready(io_dma_data_ready),
    .io_dma_data_valid(io_dma_data_valid), .io_dma_data_bits_data(io_dma_data_bits_data),
    .io_dma_data_bits_last(io_dma_data_bits_last), .io_wr_idx(io_wr_idx),
    .io_uploaded_cnt(io_uploaded_cnt)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int next_tag = 0;
  int exp_q[$];

  function automatic logic [511:0] mk(input int t);
    return {16{32'(t) ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed low word %0h expected low word %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push();
    int cyc = 0;
    io_rec_in_valid = 1'b1;
    io_rec_in_bits  = mk(next_tag);
    while (!io_rec_in_ready && cyc < 200) begin
      step();
      cyc++;
    end
    chk("push_ready", 64'(io_rec_in_ready), 64'd1);
    step();
    io_rec_in_valid = 1'b0;
    exp_q.push_back(next_tag);
    next_tag++;
  endtask

  // Wait for a command, accept it, then take up to 'take' beats checking order and last.
  task automatic expect_burst(input logic [63:0] va, input logic [31:0] len,
                              input bit rnd, input int take);
    int cyc = 0;
    int nb = int'(len >> 6);
    int beat = 0;
    bit stalled = 1'b0;
    logic [511:0] held = '0;
    int et;
    io_dma_cmd_ready = 1'b0;
    while (!io_dma_cmd_valid && cyc < 300) begin
      step();
      cyc++;
    end
    chk("cmd_valid", 64'(io_dma_cmd_valid), 64'd1);
    chk("cmd_vaddr", io_dma_cmd_bits_vaddr, va);
    chk("cmd_length", 64'(io_dma_cmd_bits_length), 64'(len));
    io_dma_cmd_ready = 1'b1;
    step();
    io_dma_cmd_ready = 1'b0;
    cyc = 0;
    while (beat < take && cyc < 500) begin
      io_dma_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (io_dma_data_valid) begin
        if (stalled) chk_rec("stall_data_stable", io_dma_data_bits_data, held);
        if (io_dma_data_ready) begin
          et = -1;
          if (exp_q.size() > 0) et = exp_q.pop_front();
          chk_rec("beat_data", io_dma_data_bits_data, mk(et));
          chk("beat_last", 64'(io_dma_data_bits_last), 64'(beat == nb - 1));
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = io_dma_data_bits_data;
        end
      end
      step();
      cyc++;
    end
    io_dma_data_ready = 1'b0;
    chk("beats_taken", 64'(beat), 64'(take));
  endtask

  initial begin
    int cyc;
    bit seen;
    reset = 1'b1;
    io_rec_in_valid = 1'b0;
    io_rec_in_bits = '0;
    io_base_vaddr = 64'h1000;
    io_ring_entries = 32'd8;
    io_batch_len = 32'd4;
    io_flush_cycles = 32'd100;
    io_dma_cmd_ready = 1'b0;
    io_dma_data_ready = 1'b0;
    repeat (2) step();
    chk("rst_rec_ready", 64'(io_rec_in_ready), 64'd0);
    chk("rst_cmd_valid", 64'(io_dma_cmd_valid), 64'd0);
    chk("rst_data_valid", 64'(io_dma_data_valid), 64'd0);
    chk("rst_wr_idx", 64'(io_wr_idx), 64'd0);
    chk("rst_uploaded", 64'(io_uploaded_cnt), 64'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 64'(io_rec_in_ready), 64'd1);

    // Full batch of 4
    repeat (4) push();
    expect_burst(64'h1000, 32'd256, 1'b0, 4);
    chk("t1_wr_idx", 64'(io_wr_idx), 64'd4);
    chk("t1_uploaded", 64'(io_uploaded_cnt), 64'd4);

    // Partial batch flushed on idle
    io_flush_cycles = 32'd10;
    repeat (2) push();
    cyc = 0;
    while (!io_dma_cmd_valid && cyc < 200) begin
      step();
      cyc++;
    end
    chk("t2_flush_latency", 64'(cyc), 64'd11);
    expect_burst(64'h1100, 32'd128, 1'b0, 2);
    chk("t2_wr_idx", 64'(io_wr_idx), 64'd6);

    // Shrink ring to 6: out-of-range wr_idx restarts at 0, then wrap split
    io_ring_entries = 32'd6;
    repeat (4) push();
    expect_burst(64'h1000, 32'd256, 1'b0, 4);
    chk("t3_wr_idx_a", 64'(io_wr_idx), 64'd4);
    repeat (4) push();
    expect_burst(64'h1100, 32'd128, 1'b0, 2);
    chk("t3_wrap", 64'(io_wr_idx), 64'd0);
    expect_burst(64'h1000, 32'd128, 1'b0, 2);
    chk("t3_wr_idx_b", 64'(io_wr_idx), 64'd2);
    chk("t3_uploaded", 64'(io_uploaded_cnt), 64'd14);

    // Command stall while the FIFO fills, then randomised data backpressure
    io_ring_entries = 32'd64;
    io_batch_len = 32'd16;
    io_flush_cycles = 32'd1000;
    repeat (16) push();
    step();
    chk("t4_cmd_up", 64'(io_dma_cmd_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      io_rec_in_valid = io_rec_in_ready;
      if (io_rec_in_ready) begin
        io_rec_in_bits = mk(next_tag);
        exp_q.push_back(next_tag);
        next_tag++;
      end
      chk("t4_cmd_hold", 64'(io_dma_cmd_valid), 64'd1);
      chk("t4_vaddr_hold", io_dma_cmd_bits_vaddr, 64'h1080);
      chk("t4_len_hold", 64'(io_dma_cmd_bits_length), 64'd1024);
      chk("t4_no_data", 64'(io_dma_data_valid), 64'd0);
      step();
    end
    io_rec_in_valid = 1'b0;
    chk("t4_full", 64'(io_rec_in_ready), 64'd0);
    chk("t4_queued", 64'(exp_q.size()), 64'd32);
    expect_burst(64'h1080, 32'd1024, 1'b1, 16);
    expect_burst(64'h1480, 32'd1024, 1'b1, 16);
    chk("t4_wr_idx", 64'(io_wr_idx), 64'd34);
    chk("t4_uploaded", 64'(io_uploaded_cnt), 64'd46);
    chk("t4_ready_back", 64'(io_rec_in_ready), 64'd1);

    // Disabled ring holds records until enabled
    io_ring_entries = 32'd0;
    io_batch_len = 32'd4;
    io_flush_cycles = 32'd10;
    repeat (5) push();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen |= io_dma_cmd_valid;
      step();
    end
    chk("t5_no_cmd", 64'(seen), 64'd0);
    chk("t5_wr_idx_held", 64'(io_wr_idx), 64'd34);
    io_ring_entries = 32'd8;
    expect_burst(64'h1000, 32'd256, 1'b0, 4);
    expect_burst(64'h1100, 32'd64, 1'b0, 1);
    chk("t5_wr_idx", 64'(io_wr_idx), 64'd5);
    chk("t5_uploaded", 64'(io_uploaded_cnt), 64'd51);

    // Reset mid-burst; 64-bit address carry on the abandoned burst
    io_base_vaddr = 64'h1_FFFF_FF00;
    io_ring_entries = 32'd16;
    repeat (4) push();
    expect_burst(64'h2_0000_0040, 32'd256, 1'b0, 2);
    reset = 1'b1;
    step();
    chk("t6_cmd_valid", 64'(io_dma_cmd_valid), 64'd0);
    chk("t6_data_valid", 64'(io_dma_data_valid), 64'd0);
    chk("t6_rec_ready", 64'(io_rec_in_ready), 64'd0);
    chk("t6_wr_idx", 64'(io_wr_idx), 64'd0);
    chk("t6_uploaded", 64'(io_uploaded_cnt), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    step();
    chk("t6_ready_back", 64'(io_rec_in_ready), 64'd1);
    chk("t6_fifo_empty", 64'(io_dma_data_valid), 64'd0);
    repeat (4) push();
    expect_burst(64'h1_FFFF_FF00, 32'd256, 1'b0, 4);
    chk("t6_wr_idx_new", 64'(io_wr_idx), 64'd4);
    chk("t6_uploaded_new", 64'(io_uploaded_cnt), 64'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
